// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer:
// the FSM state encoding and the partial-word counter width.
package sipo_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_e;

  // Counter width for a word of n bits; it must hold counts 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_DEFAULT     = 8;
  localparam int CNT_W_DEFAULT = cnt_width(N_DEFAULT);

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and parallel output handshake bundle of the deserializer.
//
// Handshake semantics: a serial bit transfers on a rising edge where
// s_valid & s_ready; a word leaves the output buffer on a rising edge where
// p_valid & p_ready, which is exactly when the p_load strobe is high.
// p_data is stable while p_valid=1 and p_ready=0.
interface sipo_deserializer_if #(
  parameter int N = 8
) ();
  logic         s_in;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] p_data;
  logic         p_valid;
  logic         p_ready;
  logic         p_load;

  modport master (
    output s_in, s_valid, p_ready,
    input  s_ready, p_data, p_valid, p_load
  );

  modport slave (
    input  s_in, s_valid, p_ready,
    output s_ready, p_data, p_valid, p_load
  );
endinterface

// File: rtl/sipo_deserializer_word_out_buffer.sv
// One-word output holding register with a valid/ready drain; p_load marks
// the edge on which the downstream register takes the word.
module word_out_buffer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load_en,
  input  logic [N-1:0] load_data,
  input  logic         p_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  output logic         p_load
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  assign p_load  = valid_q & p_ready;
  assign p_data  = data_q;
  assign p_valid = valid_q;

  // A new word and a drain on the same edge keep valid high (no bubble).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load_en) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (p_load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel front end: shifts in N valid-qualified bits, then hands
// the completed word to a one-deep output buffer; stalls only when both are full.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  sipo_deserializer_if.slave   bus,
  output logic [CW-1:0]        bit_cnt,
  output state_e               state_dbg
);

  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d, sr_shifted;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;
  logic           last_bit;
  logic           buf_load_en;
  logic [N-1:0]   buf_load_data;

  assign bus.s_ready = (state_q != STALL);
  assign accept      = bus.s_valid & bus.s_ready;
  assign last_bit    = accept && (cnt_q == CW'(N - 1));
  assign bit_cnt     = cnt_q;
  assign state_dbg   = state_q;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shifted = {sr_q[N-2:0], bus.s_in};
    end else begin : g_lsb_first
      assign sr_shifted = {bus.s_in, sr_q[N-1:1]};
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    buf_load_en   = 1'b0;
    buf_load_data = sr_shifted;
    if (clr) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_d    = sr_shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            sr_d = sr_shifted;
            if (last_bit) begin
              cnt_d = '0;
              // The buffer is usable if empty or being drained this very edge.
              if (!bus.p_valid || bus.p_load) begin
                buf_load_en = 1'b1;
                state_d     = IDLE;
              end else begin
                state_d = STALL;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        STALL: begin
          if (bus.p_load) begin
            buf_load_en   = 1'b1;
            buf_load_data = sr_q;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  word_out_buffer #(.N(N)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load_en   (buf_load_en),
    .load_data (buf_load_data),
    .p_ready   (bus.p_ready),
    .p_data    (bus.p_data),
    .p_valid   (bus.p_valid),
    .p_load    (bus.p_load)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: an MSB-first and an LSB-first instance share
// one stimulus stream and are compared every cycle against a bit-queue model.
module tb_sipo_deserializer;
  import sipo_deserializer_pkg::*;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic s_in, s_valid, p_ready;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.N(N)) if_m ();
  sipo_deserializer_if #(.N(N)) if_l ();

  assign if_m.s_in    = s_in;
  assign if_m.s_valid = s_valid;
  assign if_m.p_ready = p_ready;
  assign if_l.s_in    = s_in;
  assign if_l.s_valid = s_valid;
  assign if_l.p_ready = p_ready;

  logic [2:0] cnt_m, cnt_l;
  state_e     st_m, st_l;

  sipo_deserializer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst (rst), .clr (clr), .bus (if_m),
    .bit_cnt (cnt_m), .state_dbg (st_m)
  );

  sipo_deserializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .clr (clr), .bus (if_l),
    .bit_cnt (cnt_l), .state_dbg (st_l)
  );

  // ---------------- reference model ----------------
  // bits_q holds the partial word in arrival order; out_* is the output
  // buffer, pend_* the complete word parked while the buffer is full.
  bit         bits_q[$];
  logic [7:0] out_m, out_l, pend_m, pend_l;
  bit         out_v, pend_v;

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] assemble(input bit msb);
    logic [7:0] w;
    w = '0;
    foreach (bits_q[i]) begin
      if (msb) w = (w << 1) | 8'(bits_q[i]);
      else     w = w | (8'(bits_q[i]) << i);
    end
    return w;
  endfunction

  function automatic state_e exp_state();
    if (pend_v)              return STALL;
    if (bits_q.size() == 0)  return IDLE;
    return SHIFT;
  endfunction

  task automatic model_reset();
    bits_q.delete();
    out_m = '0; out_l = '0; pend_m = '0; pend_l = '0;
    out_v = 1'b0; pend_v = 1'b0;
  endtask

  task automatic check_all();
    chk("s_ready_m", if_m.s_ready, !pend_v);
    chk("s_ready_l", if_l.s_ready, !pend_v);
    chk("p_valid_m", if_m.p_valid, out_v);
    chk("p_valid_l", if_l.p_valid, out_v);
    chk("p_load_m",  if_m.p_load,  out_v && p_ready);
    chk("p_load_l",  if_l.p_load,  out_v && p_ready);
    chk("p_data_m",  if_m.p_data,  out_m);
    chk("p_data_l",  if_l.p_data,  out_l);
    chk("bit_cnt_m", cnt_m, bits_q.size());
    chk("bit_cnt_l", cnt_l, bits_q.size());
    chk("state_m",   st_m,  exp_state());
    chk("state_l",   st_l,  exp_state());
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at the falling edge, check, advance model at the rising edge.
  task automatic step(input logic si, input logic sv, input logic pr, input logic cl);
    bit acc, ld, loaded;
    logic [7:0] wm, wl;
    s_in = si; s_valid = sv; p_ready = pr; clr = cl;
    #1;
    check_all();
    if (if_m.p_load && exp_q.size() > 0) chk("sb_word", if_m.p_data, exp_q.pop_front());
    acc = sv && !pend_v;
    ld  = out_v && pr;
    @(posedge clk);
    if (cl) begin
      model_reset();
    end else begin
      loaded = 1'b0;
      if (acc) begin
        bits_q.push_back(si);
        if (bits_q.size() == N) begin
          wm = assemble(1'b1);
          wl = assemble(1'b0);
          bits_q.delete();
          if (!out_v || pr) begin
            out_m = wm; out_l = wl; out_v = 1'b1; loaded = 1'b1;
          end else begin
            pend_m = wm; pend_l = wl; pend_v = 1'b1;
          end
        end
      end else if (pend_v && ld) begin
        out_m = pend_m; out_l = pend_l; pend_v = 1'b0; loaded = 1'b1;
      end
      if (!loaded && ld) out_v = 1'b0;
    end
    @(negedge clk);
  endtask

  // Sends a word first-bit-first from bit 7 down to bit 0, retrying stalled bits.
  task automatic send_word(input logic [7:0] w, input logic pr, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      int  tries;
      bit  v, a;
      tries = 0;
      do begin
        v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        a = v && !pend_v;
        step(w[i], v, pr, 1'b0);
        tries++;
      end while (!a && tries < 50);
      if (!a) chk("send_timeout", 1'b0, 1'b1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; s_in = 1'b0; s_valid = 1'b0; p_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_p_valid", if_m.p_valid, 1'b0);
    chk("rst_bit_cnt", cnt_m, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word after three bits, then a clean 0xC3.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_p_valid", if_m.p_valid, 1'b0);
    chk("mid_rst_bit_cnt", cnt_m, 3'd0);
    chk("mid_rst_p_data",  if_m.p_data, 8'h00);
    chk("mid_rst_s_ready", if_m.s_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_word(8'hC3, 1'b1, 1'b0);
    chk("c3_msb", if_m.p_data, 8'hC3);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Fixed patterns, both bit orders.
    send_word(8'hA5, 1'b1, 1'b0);
    chk("a5_msb", if_m.p_data, 8'hA5);
    chk("a5_lsb", if_l.p_data, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hC0, 1'b1, 1'b0);
    chk("c0_lsb", if_l.p_data, 8'h03);
    chk("c0_msb", if_m.p_data, 8'hC0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: second word parks in the shift register.
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("bp_state",   st_m, STALL);
    chk("bp_s_ready", if_m.s_ready, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #0;
    p_ready = 1'b1;
    #1;
    chk("bp_first",  if_m.p_data, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_second", if_m.p_data, 8'hFF);
    chk("bp_ready",  if_m.s_ready, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back with random valid gaps, checked by the scoreboard.
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
    send_word(8'h12, 1'b1, 1'b1);
    send_word(8'h34, 1'b1, 1'b1);
    send_word(8'h56, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sb_all_loaded", exp_q.size(), 0);

    // clr after five bits; the bit presented with clr is dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_bit_cnt", cnt_m, 3'd0);
    chk("clr_p_valid", if_m.p_valid, 1'b0);
    send_word(8'h96, 1'b1, 1'b0);
    chk("clr_next_word", if_m.p_data, 8'h96);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // clr while stalled drops both the buffered and the parked word.
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_stall_p_valid", if_m.p_valid, 1'b0);
    chk("clr_stall_s_ready", if_m.s_ready, 1'b1);
    chk("clr_stall_state",   st_m, IDLE);
    send_word(8'h3C, 1'b1, 1'b0);
    chk("clr_stall_next", if_m.p_data, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
